pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register, successor to the fixed-width D/E latch.
- One instance sits at every stage boundary (F/D, D/E, E/M, M/W) of the 5-stage MIPS core.
- Carries a packed data payload, register addresses, PC, delay-slot flag, exception code and a valid bit.
- Supports four control actions (flush, hold, bubble, load) and exports a $0-filtered write-forwarding tap.

---
 rtl/pipe_stage_reg.sv | 166 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with flush/hold/bubble/load control and a
// $0-filtered forwarding tap. Define PIPE_STAGE_PERF_CNT_EN to build the stall/bubble counters.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NDATA  = 4,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned EXC_W  = 5,
  parameter int unsigned PC_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    stall,
  input  logic                    bubble,
  input  logic                    in_valid,
  input  logic [NDATA*DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]        in_a1,
  input  logic [REG_W-1:0]        in_a2,
  input  logic [REG_W-1:0]        in_a3,
  input  logic                    in_regwrite,
  input  logic [PC_W-1:0]         in_pc,
  input  logic                    in_bd,
  input  logic [EXC_W-1:0]        in_exc,
  output logic                    out_valid,
  output logic [NDATA*DATA_W-1:0] out_data,
  output logic [REG_W-1:0]        out_a1,
  output logic [REG_W-1:0]        out_a2,
  output logic [REG_W-1:0]        out_a3,
  output logic                    out_regwrite,
  output logic [PC_W-1:0]         out_pc,
  output logic                    out_bd,
  output logic [EXC_W-1:0]        out_exc,
  output logic                    fwd_we,
  output logic [REG_W-1:0]        fwd_a3,
  output logic [31:0]             bubble_cnt,
  output logic [31:0]             stall_cnt
);

  logic                    valid_q, valid_d;
  logic [NDATA*DATA_W-1:0] data_q, data_d;
  logic [REG_W-1:0]        a1_q, a1_d;
  logic [REG_W-1:0]        a2_q, a2_d;
  logic [REG_W-1:0]        a3_q, a3_d;
  logic                    regwrite_q, regwrite_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic                    bd_q, bd_d;
  logic [EXC_W-1:0]        exc_q, exc_d;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    a3_d       = a3_q;
    regwrite_d = regwrite_q;
    pc_d       = pc_q;
    bd_d       = bd_q;
    exc_d      = exc_q;
    if (req) begin
      valid_d    = 1'b0;
      data_d     = '0;
      a1_d       = '0;
      a2_d       = '0;
      a3_d       = '0;
      regwrite_d = 1'b0;
      pc_d       = '0;
      bd_d       = 1'b0;
      exc_d      = '0;
    end else if (stall) begin
      // Hold: defaults above already keep every register.
    end else if (bubble) begin
      // NOP that still carries PC and delay-slot flag so a later EPC is correct.
      valid_d    = 1'b0;
      data_d     = '0;
      a1_d       = '0;
      a2_d       = '0;
      a3_d       = '0;
      regwrite_d = 1'b0;
      pc_d       = in_pc;
      bd_d       = in_bd;
      exc_d      = '0;
    end else begin
      valid_d    = in_valid;
      data_d     = in_data;
      a1_d       = in_a1;
      a2_d       = in_a2;
      a3_d       = in_a3;
      regwrite_d = in_valid & in_regwrite;
      pc_d       = in_pc;
      bd_d       = in_bd;
      exc_d      = in_valid ? in_exc : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      a3_q       <= '0;
      regwrite_q <= 1'b0;
      pc_q       <= '0;
      bd_q       <= 1'b0;
      exc_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      a3_q       <= a3_d;
      regwrite_q <= regwrite_d;
      pc_q       <= pc_d;
      bd_q       <= bd_d;
      exc_q      <= exc_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign out_a1       = a1_q;
  assign out_a2       = a2_q;
  assign out_a3       = a3_q;
  assign out_regwrite = regwrite_q;
  assign out_pc       = pc_q;
  assign out_bd       = bd_q;
  assign out_exc      = exc_q;

  // Writes to $0 are architecturally discarded, so never advertise them for forwarding.
  assign fwd_we = valid_q & regwrite_q & (a3_q != '0);
  assign fwd_a3 = fwd_we ? a3_q : '0;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        bubble_take, stall_take;

  assign stall_take  = ~req & stall;
  assign bubble_take = ~req & ~stall & bubble;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (bubble_take && bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (stall_take && stall_cnt_q != 32'hFFFF_FFFF)   stall_cnt_d  = stall_cnt_q + 32'd1;
  end

  // Counters clear only on reset; a flush must not lose the statistics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`else
  assign bubble_cnt = 32'd0;
  assign stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised self-checking bench for pipe_stage_reg against a behavioural stage model;
// counter expectations follow PIPE_STAGE_PERF_CNT_EN.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, req, stall, bubble, in_valid, in_regwrite, in_bd;
  logic [127:0] in_data;
  logic [4:0]   in_a1, in_a2, in_a3, in_exc;
  logic [31:0]  in_pc;
  logic         out_valid, out_regwrite, out_bd, fwd_we;
  logic [127:0] out_data;
  logic [4:0]   out_a1, out_a2, out_a3, out_exc, fwd_a3;
  logic [31:0]  out_pc, bubble_cnt, stall_cnt;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .bubble(bubble),
    .in_valid(in_valid), .in_data(in_data), .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3),
    .in_regwrite(in_regwrite), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
    .out_valid(out_valid), .out_data(out_data), .out_a1(out_a1), .out_a2(out_a2),
    .out_a3(out_a3), .out_regwrite(out_regwrite), .out_pc(out_pc), .out_bd(out_bd),
    .out_exc(out_exc), .fwd_we(fwd_we), .fwd_a3(fwd_a3),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         valid;
    logic [127:0] data;
    logic [4:0]   a1, a2, a3;
    logic         rw;
    logic [31:0]  pc;
    logic         bd;
    logic [4:0]   exc;
  } stage_t;

  stage_t      m;
  logic [31:0] m_bcnt, m_scnt;
  bit          started = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Reference: what the stage must hold after each edge, straight from the action priority.
  always @(posedge clk) begin
    if (!reset) begin
      m = '0; m_bcnt = 0; m_scnt = 0; started = 1'b1;
    end else if (req) begin
      m = '0;
    end else if (stall) begin
      if (PerfEn) m_scnt = sat_inc(m_scnt);
    end else if (bubble) begin
      m = '0; m.pc = in_pc; m.bd = in_bd;
      if (PerfEn) m_bcnt = sat_inc(m_bcnt);
    end else begin
      m.valid = in_valid; m.data = in_data; m.a1 = in_a1; m.a2 = in_a2; m.a3 = in_a3;
      m.pc = in_pc; m.bd = in_bd;
      m.rw  = in_valid ? in_regwrite : 1'b0;
      m.exc = in_valid ? in_exc : 5'd0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic exp_we;
      exp_we = m.valid && m.rw && (m.a3 != 5'd0);
      chk("valid", out_valid, m.valid);
      chk("data", out_data, m.data);
      chk("a1", out_a1, m.a1);
      chk("a2", out_a2, m.a2);
      chk("a3", out_a3, m.a3);
      chk("regwrite", out_regwrite, m.rw);
      chk("pc", out_pc, m.pc);
      chk("bd", out_bd, m.bd);
      chk("exc", out_exc, m.exc);
      chk("fwd_we", fwd_we, exp_we);
      chk("fwd_a3", fwd_a3, exp_we ? m.a3 : 5'd0);
      chk("bubble_cnt", bubble_cnt, m_bcnt);
      chk("stall_cnt", stall_cnt, m_scnt);
    end
  end

  task automatic drive(input bit v, input logic [4:0] a3, input bit rw, input logic [31:0] pc,
                       input logic [127:0] d, input bit bd, input logic [4:0] exc);
    in_valid = v; in_a3 = a3; in_regwrite = rw; in_pc = pc; in_data = d; in_bd = bd;
    in_exc = exc; in_a1 = 5'd3; in_a2 = 5'd4;
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; stall = 1'b0; bubble = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 32'hDEAD, 128'hFF, 1'b1, 5'd3);
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_pc", out_pc, 32'h0);

    reset = 1'b1;
    drive(1'b1, 5'd8, 1'b1, 32'h3000, 128'h1234, 1'b0, 5'd0);
    @(negedge clk);
    chk("ld_pc", out_pc, 32'h3000);
    chk("ld_fwd_we", fwd_we, 1'b1);
    chk("ld_fwd_a3", fwd_a3, 5'd8);
    chk("ld_word0", out_data[31:0], 32'h1234);

    drive(1'b1, 5'd0, 1'b1, 32'h3004, 128'h5, 1'b0, 5'd0);
    @(negedge clk);
    chk("r0_regwrite", out_regwrite, 1'b1);
    chk("r0_fwd_we", fwd_we, 1'b0);
    chk("r0_fwd_a3", fwd_a3, 5'd0);

    bubble = 1'b1;
    drive(1'b1, 5'd9, 1'b1, 32'h3008, 128'h77, 1'b1, 5'd10);
    @(negedge clk);
    chk("bub_pc", out_pc, 32'h3008);
    chk("bub_bd", out_bd, 1'b1);
    chk("bub_exc", out_exc, 5'd0);
    chk("bub_valid", out_valid, 1'b0);
    chk("bub_fwd_we", fwd_we, 1'b0);
    chk("bub_cnt", bubble_cnt, PerfEn ? 32'd1 : 32'd0);

    bubble = 1'b0;
    drive(1'b1, 5'd9, 1'b1, 32'h3004, 128'hABCD, 1'b0, 5'd0);
    @(negedge clk);
    stall = 1'b1; bubble = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 20), 1'b0, 32'h4000 + 32'(i), 128'(i), 1'b1, 5'd2);
      @(negedge clk);
      chk("hold_pc", out_pc, 32'h3004);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_a3", out_a3, 5'd9);
    end
    chk("hold_scnt", stall_cnt, PerfEn ? 32'd3 : 32'd0);
    chk("hold_bcnt", bubble_cnt, PerfEn ? 32'd1 : 32'd0);

    bubble = 1'b0; req = 1'b1;
    @(negedge clk);
    chk("fl_pc", out_pc, 32'h0);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_data", out_data, 128'h0);
    chk("fl_scnt", stall_cnt, PerfEn ? 32'd3 : 32'd0);
    req = 1'b0; stall = 1'b0;

    drive(1'b0, 5'd12, 1'b1, 32'h5000, 128'h99, 1'b0, 5'd7);
    @(negedge clk);
    chk("inv_rw", out_regwrite, 1'b0);
    chk("inv_exc", out_exc, 5'd0);
    chk("inv_pc", out_pc, 32'h5000);

`ifdef PIPE_STAGE_PERF_CNT_EN
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_q;
    m_scnt = 32'hFFFF_FFFD;
    stall = 1'b1;
    repeat (4) @(negedge clk);
    chk("sat_scnt", stall_cnt, 32'hFFFF_FFFF);
    stall = 1'b0;
`endif

    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 99) >= 2);
      req    = ($urandom_range(0, 99) < 5);
      stall  = ($urandom_range(0, 99) < 20);
      bubble = ($urandom_range(0, 99) < 20);
      drive(1'($urandom), 5'($urandom_range(0, 31)), 1'($urandom), $urandom,
            {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 5'($urandom));
      in_a1 = 5'($urandom); in_a2 = 5'($urandom);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
